// File: rtl/arrow_spawn_if.sv
// Handshake bundle between the arrow spawn scheduler and its environment
// (song control, random source and arrow lanes).
interface arrow_spawn_if;
  logic        start;
  logic        stop;
  logic [17:0] rnd;
  logic        rnd_adv;
  logic [3:0]  lane_ready;
  logic [3:0]  spawn;
  logic        busy;
  logic        done;
  logic [7:0]  spawn_count;
  logic [7:0]  drop_count;

  // Environment side: drives song control, random word and lane readiness
  modport master (
    output start, stop, rnd, lane_ready,
    input  rnd_adv, spawn, busy, done, spawn_count, drop_count
  );

  // Scheduler side
  modport slave (
    input  start, stop, rnd, lane_ready,
    output rnd_adv, spawn, busy, done, spawn_count, drop_count
  );
endinterface

// File: rtl/arrow_spawn_scheduler.sv
// Beat-paced note scheduler: waits a random number of beats, draws a lane,
// and spawns an arrow on the first ready lane (dropping after four tries).
module arrow_spawn_scheduler #(
  parameter int unsigned TICK_DIV = 25,
  parameter int unsigned GAP_MIN  = 2,
  parameter logic [3:0]  GAP_MASK = 4'hF,
  parameter int unsigned NOTES    = 64
) (
  input  logic         clk,
  input  logic         reset,
  arrow_spawn_if.slave bus
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GAP_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TOT_W = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_DRAW  = 3'd2,
    S_ISSUE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [1:0]         lane_q, lane_d;
  logic [3:0]         extra_q, extra_d;
  logic [1:0]         tries_q, tries_d;
  logic [CNT_W-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [3:0]         spawn_c;
  logic               adv_c;
  logic               done_c;
  logic               note_end;
  logic [TOT_W-1:0]   notes_after;
  logic               unused_rnd;

  assign unused_rnd  = ^bus.rnd[17:6];
  assign notes_after = TOT_W'(spawn_cnt_q) + TOT_W'(drop_cnt_q) + TOT_W'(1);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      lane_q      <= '0;
      extra_q     <= '0;
      tries_q     <= '0;
      spawn_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      lane_q      <= lane_d;
      extra_q     <= extra_d;
      tries_q     <= tries_d;
      spawn_cnt_q <= spawn_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Next-state and output decode; abort (stop or reset) suppresses every pulse
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    gap_d       = gap_q;
    lane_d      = lane_q;
    extra_d     = extra_q;
    tries_d     = tries_q;
    spawn_cnt_d = spawn_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    spawn_c     = 4'b0000;
    adv_c       = 1'b0;
    done_c      = 1'b0;
    note_end    = 1'b0;

    if (reset || (bus.stop && (state_q != S_IDLE))) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d     = S_WAIT;
            gap_d       = GAP_W'(GAP_MIN);
            div_d       = '0;
            spawn_cnt_d = '0;
            drop_cnt_d  = '0;
          end
        end

        S_WAIT: begin
          if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_d = '0;
            if (gap_q == GAP_W'(1)) begin
              state_d = S_DRAW;
            end else begin
              gap_d = gap_q - GAP_W'(1);
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end

        // Lane and extra gap come from the word present before the advance
        S_DRAW: begin
          adv_c   = 1'b1;
          lane_d  = bus.rnd[1:0];
          extra_d = bus.rnd[5:2] & GAP_MASK;
          tries_d = '0;
          state_d = S_ISSUE;
        end

        S_ISSUE: begin
          if (bus.lane_ready[lane_q]) begin
            spawn_c     = 4'b0001 << lane_q;
            spawn_cnt_d = spawn_cnt_q + CNT_W'(1);
            note_end    = 1'b1;
          end else if (tries_q == 2'd3) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            note_end   = 1'b1;
          end else begin
            lane_d  = lane_q + 2'd1;
            tries_d = tries_q + 2'd1;
          end

          if (note_end) begin
            if (notes_after >= TOT_W'(NOTES)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
              gap_d   = GAP_W'(GAP_MIN) + GAP_W'(extra_q);
              div_d   = '0;
            end
          end
        end

        S_DONE: begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.spawn       = spawn_c;
  assign bus.rnd_adv     = adv_c;
  assign bus.done        = done_c;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.spawn_count = spawn_cnt_q;
  assign bus.drop_count  = drop_cnt_q;

endmodule
